aurora_pkt_tx: RTL and testbench

//  Downstream stage of the fifo pool. Runs on the Aurora user clock (the pool's read clock).

---
 rtl/aurora_pkt_tx_if.sv | 27 ++
 rtl/aurora_pkt_tx.sv | 212 +++++++++++++++++++++
 tb/tb_aurora_pkt_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_pkt_tx_if.sv
// Bus bundle between the packet framer, the pool FIFO read port and the
// Aurora LocalLink TX port.
//   fifo_rd_empty / fifo_rd_data / fifo_rd_en : pool FIFO read side (standard FIFO,
//                                               data valid one cycle after rd_en)
//   tx_d / tx_src_rdy_n / tx_sof_n / tx_eof_n : LocalLink TX data and framing, active-low
//   tx_dst_rdy_n                              : LocalLink destination ready, active-low
// master = framer side, slave = FIFO + link side.
interface aurora_pkt_tx_if;
    logic        fifo_rd_empty;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic [15:0] tx_d;
    logic        tx_src_rdy_n;
    logic        tx_sof_n;
    logic        tx_eof_n;
    logic        tx_dst_rdy_n;

    modport master (
        input  fifo_rd_empty, fifo_rd_data, tx_dst_rdy_n,
        output fifo_rd_en, tx_d, tx_src_rdy_n, tx_sof_n, tx_eof_n
    );

    modport slave (
        output fifo_rd_empty, fifo_rd_data, tx_dst_rdy_n,
        input  fifo_rd_en, tx_d, tx_src_rdy_n, tx_sof_n, tx_eof_n
    );
endinterface

// File: rtl/aurora_pkt_tx.sv
// Aurora packet transmitter: drains one buffered packet from the pool FIFO and
// frames it on LocalLink as HDR_WORD, sequence number, PKT_WORDS payload words
// and a 16-bit payload checksum trailer.
// Ports:
//   clk             Aurora user clock (only clock)
//   rst_n           synchronous active-low reset
//   pkt_ready_async pool packet_full from the write-clock domain (2-flop synced)
//   bus             aurora_pkt_tx_if.master: FIFO read port and LocalLink TX port
//   busy            high from HDR through TRL
//   pkt_seq         frames sent, increments on trailer accept
//   underrun        sticky timeout-pad flag (0 unless pad feature is built in)
// Optional feature macro: PKT_TX_UNDERRUN_PAD_EN adds the TIMEOUT stall counter
// that pads the rest of a starved packet with zero words.
module aurora_pkt_tx #(
    parameter int unsigned PKT_WORDS = 280,
    parameter logic [15:0] HDR_WORD  = 16'hBE11
`ifdef PKT_TX_UNDERRUN_PAD_EN
    ,
    parameter int unsigned TIMEOUT   = 1023
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pkt_ready_async,
    aurora_pkt_tx_if.master        bus,
    output logic                   busy,
    output logic [15:0]            pkt_seq,
    output logic                   underrun
);
    typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, TRL} state_e;
    localparam int unsigned CNT_W = $clog2(PKT_WORDS + 1);

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [15:0]        skid0_q, skid0_d, skid1_q, skid1_d;
    logic [1:0]         skid_cnt_q, skid_cnt_d;
    logic               in_flight_q, in_flight_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, pay_cnt_q, pay_cnt_d;
    logic [15:0]        csum_q, csum_d, pkt_seq_q, pkt_seq_d;

    logic               pad, head_valid, pay_valid, accept, pay_acc;
    logic               bypass, push, pop, rd_en;
    logic [15:0]        head, pay_data, tx_d;
    logic               src_rdy_n, sof_n, eof_n;

    // A word arriving from the FIFO is presented directly when the skid is
    // empty, so a steady stream needs no buffering and runs at one beat/clk.
    assign head_valid = (skid_cnt_q != 2'd0) || in_flight_q;
    assign head       = (skid_cnt_q != 2'd0) ? skid0_q : bus.fifo_rd_data;
    assign pay_valid  = pad || head_valid;
    assign pay_data   = pad ? 16'h0000 : head;

    always_comb begin
        src_rdy_n = 1'b1;
        sof_n     = 1'b1;
        eof_n     = 1'b1;
        tx_d      = '0;
        unique case (state_q)
            HDR: begin src_rdy_n = 1'b0; sof_n = 1'b0; tx_d = HDR_WORD; end
            SEQ: begin src_rdy_n = 1'b0; tx_d = pkt_seq_q; end
            PAY: begin src_rdy_n = !pay_valid; tx_d = pay_data; end
            TRL: begin src_rdy_n = 1'b0; eof_n = 1'b0; tx_d = csum_q; end
            default: ;
        endcase
    end

    assign accept  = !src_rdy_n && !bus.tx_dst_rdy_n;
    assign pay_acc = accept && (state_q == PAY);
    assign bypass  = pay_acc && !pad && (skid_cnt_q == 2'd0) && in_flight_q;
    assign pop     = pay_acc && !pad && (skid_cnt_q != 2'd0);
    assign push    = in_flight_q && !bypass && !pad;
    assign rd_en   = ((state_q == SEQ) || (state_q == PAY)) && !bus.fifo_rd_empty
                     && ((skid_cnt_q + {1'b0, in_flight_q}) < 2'd2)
                     && (rd_cnt_q < CNT_W'(PKT_WORDS)) && !pad;

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q + CNT_W'(rd_en);
        in_flight_d = rd_en;
        pay_cnt_d   = pay_cnt_q;
        csum_d      = csum_q;
        pkt_seq_d   = pkt_seq_q;
        unique case (state_q)
            IDLE: if (sync2_q) state_d = HDR;
            HDR: begin
                csum_d    = '0;
                rd_cnt_d  = '0;
                pay_cnt_d = '0;
                if (accept) state_d = SEQ;
            end
            SEQ: if (accept) state_d = PAY;
            PAY: if (accept) begin
                csum_d    = csum_q + pay_data;
                pay_cnt_d = pay_cnt_q + CNT_W'(1);
                if (pay_cnt_q == CNT_W'(PKT_WORDS - 1)) state_d = TRL;
            end
            TRL: if (accept) begin
                pkt_seq_d = pkt_seq_q + 16'd1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (skid_cnt_q == 2'd0) skid0_d = bus.fifo_rd_data;
                else                    skid1_d = bus.fifo_rd_data;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = bus.fifo_rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = bus.fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            skid0_q     <= '0;
            skid1_q     <= '0;
            skid_cnt_q  <= '0;
            in_flight_q <= 1'b0;
            rd_cnt_q    <= '0;
            pay_cnt_q   <= '0;
            csum_q      <= '0;
            pkt_seq_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= pkt_ready_async;
            sync2_q     <= sync1_q;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            skid_cnt_q  <= skid_cnt_d;
            in_flight_q <= in_flight_d;
            rd_cnt_q    <= rd_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            csum_q      <= csum_d;
            pkt_seq_q   <= pkt_seq_d;
        end
    end

`ifdef PKT_TX_UNDERRUN_PAD_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               pad_q, pad_d, underrun_q, underrun_d;

    // Padding only starts when no word is held or in flight, so the skid is
    // already empty; any late FIFO reads are simply not issued afterwards.
    always_comb begin
        stall_d    = stall_q;
        pad_d      = pad_q;
        underrun_d = underrun_q;
        if (state_q == HDR) begin
            stall_d = '0;
            pad_d   = 1'b0;
        end else if ((state_q == PAY) && !pad_q) begin
            if (pay_acc) begin
                stall_d = '0;
            end else if (!head_valid) begin
                stall_d = stall_q + STALL_W'(1);
                if (stall_d == STALL_W'(TIMEOUT)) begin
                    pad_d      = 1'b1;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q    <= '0;
            pad_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            stall_q    <= stall_d;
            pad_q      <= pad_d;
            underrun_q <= underrun_d;
        end
    end

    assign pad      = pad_q;
    assign underrun = underrun_q;
`else
    assign pad      = 1'b0;
    assign underrun = 1'b0;
`endif

    assign bus.fifo_rd_en   = rd_en;
    assign bus.tx_d         = tx_d;
    assign bus.tx_src_rdy_n = src_rdy_n;
    assign bus.tx_sof_n     = sof_n;
    assign bus.tx_eof_n     = eof_n;
    assign busy             = (state_q != IDLE);
    assign pkt_seq          = pkt_seq_q;
endmodule

// File: tb/tb_aurora_pkt_tx.sv
module tb_aurora_pkt_tx;
    localparam int PKT_WORDS = 280;
    localparam logic [15:0] HDR = 16'hBE11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_ready_async = 1'b0;
    logic        busy;
    logic [15:0] pkt_seq;
    logic        underrun;

    aurora_pkt_tx_if ifc();

`ifdef PKT_TX_UNDERRUN_PAD_EN
    aurora_pkt_tx #(.TIMEOUT(16)) dut (
`else
    aurora_pkt_tx dut (
`endif
        .clk             (clk),
        .rst_n           (rst_n),
        .pkt_ready_async (pkt_ready_async),
        .bus             (ifc.master),
        .busy            (busy),
        .pkt_seq         (pkt_seq),
        .underrun        (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        sof_n;
        logic        eof_n;
        bit          pay;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] fifo_q[$];
    beat_t       e;
    int checks = 0, errors = 0;
    int cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0;
    int pay_acc = 0, reads_total = 0, cur_pay_acc = 0;
    bit   rand_en = 1'b0;
    logic dst_fixed = 1'b1;

    initial ifc.fifo_rd_data = 16'h0000;

    // FIFO model: standard (non-FWFT) read, data one cycle after rd_en
    always @(posedge clk) begin
        cyc++;
        if (ifc.fifo_rd_en === 1'b1) begin
            checks++;
            if (reads_total - (pay_acc - cur_pay_acc) >= 2) begin
                errors++;
                $display("FAIL rd_en_limit: held+in_flight=%0d, required <2", reads_total - (pay_acc - cur_pay_acc));
            end
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow: rd_en=1 with FIFO empty, required rd_en=0");
            end else begin
                ifc.fifo_rd_data <= fifo_q.pop_front();
            end
            reads_total++;
        end
    end

    // Destination-ready driver
    always @(posedge clk) begin
        #1;
        ifc.tx_dst_rdy_n = rand_en ? 1'($urandom_range(0, 1)) : dst_fixed;
    end

    // Beat monitor / scoreboard
    always @(negedge clk) begin
        ifc.fifo_rd_empty = (fifo_q.size() == 0);
        cur_pay_acc = 0;
        if (rst_n === 1'b1 && ifc.tx_src_rdy_n === 1'b0 && ifc.tx_dst_rdy_n === 1'b0) begin
            beats++;
            if (beats == 1) first_cyc = cyc;
            last_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got d=%h sof_n=%b eof_n=%b, required no beat",
                         ifc.tx_d, ifc.tx_sof_n, ifc.tx_eof_n);
            end else begin
                e = exp_q.pop_front();
                if (ifc.tx_d !== e.d || ifc.tx_sof_n !== e.sof_n || ifc.tx_eof_n !== e.eof_n) begin
                    errors++;
                    $display("FAIL beat[%0d]: got d=%h sof_n=%b eof_n=%b, required d=%h sof_n=%b eof_n=%b",
                             beats - 1, ifc.tx_d, ifc.tx_sof_n, ifc.tx_eof_n, e.d, e.sof_n, e.eof_n);
                end
                if (e.pay) begin
                    pay_acc++;
                    cur_pay_acc = 1;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        pkt_ready_async = 1'b0;
        rand_en = 1'b0;
        dst_fixed = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        fifo_q.delete();
        reads_total = 0;
        pay_acc = 0;
        beats = 0;
        rst_n = 1'b1;
    endtask

    task automatic load_words(input int first, input int count);
        for (int i = 0; i < count; i++) fifo_q.push_back(16'(first + i));
    endtask

    // Payload word i is i+1 for the first n_real words, zero pad afterwards
    task automatic push_frame(input logic [15:0] seq, input int n_real);
        logic [15:0] sum = 16'h0000;
        logic [15:0] w;
        exp_q.push_back('{d: HDR, sof_n: 1'b0, eof_n: 1'b1, pay: 1'b0});
        exp_q.push_back('{d: seq, sof_n: 1'b1, eof_n: 1'b1, pay: 1'b0});
        for (int i = 0; i < PKT_WORDS; i++) begin
            w = (i < n_real) ? 16'(i + 1) : 16'h0000;
            sum = sum + w;
            exp_q.push_back('{d: w, sof_n: 1'b1, eof_n: 1'b1, pay: (i < n_real)});
        end
        exp_q.push_back('{d: sum, sof_n: 1'b1, eof_n: 1'b0, pay: 1'b0});
    endtask

    task automatic start_frame();
        int n = 0;
        pkt_ready_async = 1'b1;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        pkt_ready_async = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout: busy=%b after %0d cycles, required 1", busy, n);
        end
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_timeout: %0d beats pending busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifc.tx_src_rdy_n !== 1'b1 || ifc.tx_sof_n !== 1'b1 || ifc.tx_eof_n !== 1'b1 || ifc.tx_d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_link: src/sof/eof/d=%b%b%b/%h, required 111/0000",
                     ifc.tx_src_rdy_n, ifc.tx_sof_n, ifc.tx_eof_n, ifc.tx_d);
        end
        checks++;
        if (ifc.fifo_rd_en !== 1'b0 || busy !== 1'b0 || pkt_seq !== 16'h0000 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: rd_en/busy/pkt_seq/underrun=%b/%b/%h/%b, required 0/0/0000/0",
                     ifc.fifo_rd_en, busy, pkt_seq, underrun);
        end
        do_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ifc.tx_src_rdy_n !== 1'b1) begin
            errors++;
            $display("FAIL idle_no_ready: busy=%b src_rdy_n=%b, required 0 and 1", busy, ifc.tx_src_rdy_n);
        end
    endtask

    task automatic test_full_speed();
        do_reset();
        dst_fixed = 1'b0;
        load_words(1, PKT_WORDS);
        push_frame(16'h0000, PKT_WORDS);
        repeat (2) @(negedge clk);
        start_frame();
        wait_frame(600);
        checks++;
        if (beats != PKT_WORDS + 3 || last_cyc - first_cyc != PKT_WORDS + 2) begin
            errors++;
            $display("FAIL full_speed_span: %0d beats over %0d cycles, required %0d over %0d",
                     beats, last_cyc - first_cyc + 1, PKT_WORDS + 3, PKT_WORDS + 3);
        end
        checks++;
        if (pkt_seq !== 16'h0001 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL full_speed_seq: pkt_seq=%h underrun=%b, required 0001 and 0", pkt_seq, underrun);
        end
    endtask

    task automatic test_random_dst();
        do_reset();
        rand_en = 1'b1;
        load_words(1, PKT_WORDS);
        push_frame(16'h0000, PKT_WORDS);
        repeat (2) @(negedge clk);
        start_frame();
        wait_frame(3000);
        checks++;
        if (pkt_seq !== 16'h0001) begin
            errors++;
            $display("FAIL random_dst_seq: pkt_seq=%h, required 0001", pkt_seq);
        end
        rand_en = 1'b0;
    endtask

    task automatic test_gap();
        int n = 0;
        int src_low = 0;
        do_reset();
        dst_fixed = 1'b0;
        load_words(1, 100);
        push_frame(16'h0000, PKT_WORDS);
        repeat (2) @(negedge clk);
        start_frame();
        while (pay_acc < 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.tx_src_rdy_n !== 1'b1) src_low++;
        end
        checks++;
        if (src_low != 0 || busy !== 1'b1 || pay_acc != 100) begin
            errors++;
            $display("FAIL gap_stall: src_rdy_n low %0d cycles busy=%b payload=%0d, required 0, 1, 100",
                     src_low, busy, pay_acc);
        end
        load_words(101, PKT_WORDS - 100);
        wait_frame(800);
        checks++;
        if (underrun !== 1'b0 || pkt_seq !== 16'h0001) begin
            errors++;
            $display("FAIL gap_status: underrun=%b pkt_seq=%h, required 0 and 0001", underrun, pkt_seq);
        end
    endtask

`ifdef PKT_TX_UNDERRUN_PAD_EN
    task automatic test_underrun_pad();
        do_reset();
        dst_fixed = 1'b0;
        load_words(1, 10);
        push_frame(16'h0000, 10);
        repeat (2) @(negedge clk);
        start_frame();
        wait_frame(1000);
        checks++;
        if (underrun !== 1'b1 || pkt_seq !== 16'h0001) begin
            errors++;
            $display("FAIL pad_status: underrun=%b pkt_seq=%h, required 1 and 0001", underrun, pkt_seq);
        end
    endtask
`endif

    task automatic test_seq_wrap();
        do_reset();
        dst_fixed = 1'b0;
        force dut.pkt_seq_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pkt_seq_q;
        @(negedge clk);
        checks++;
        if (pkt_seq !== 16'hFFFF) begin
            errors++;
            $display("FAIL seq_preset: pkt_seq=%h, required FFFF", pkt_seq);
        end
        load_words(1, PKT_WORDS);
        push_frame(16'hFFFF, PKT_WORDS);
        start_frame();
        wait_frame(600);
        checks++;
        if (pkt_seq !== 16'h0000) begin
            errors++;
            $display("FAIL seq_wrap: pkt_seq=%h, required 0000", pkt_seq);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int eof_low = 0;
        do_reset();
        dst_fixed = 1'b0;
        load_words(1, PKT_WORDS);
        push_frame(16'h0000, PKT_WORDS);
        repeat (2) @(negedge clk);
        start_frame();
        while (pay_acc < 150 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ifc.tx_src_rdy_n !== 1'b1 || ifc.tx_sof_n !== 1'b1 || ifc.tx_eof_n !== 1'b1 || ifc.tx_d !== 16'h0000
            || ifc.fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_link: src/sof/eof/d/rd_en=%b%b%b/%h/%b, required 111/0000/0",
                     ifc.tx_src_rdy_n, ifc.tx_sof_n, ifc.tx_eof_n, ifc.tx_d, ifc.fifo_rd_en);
        end
        checks++;
        if (busy !== 1'b0 || pkt_seq !== 16'h0000 || underrun !== 1'b0 || pay_acc != 150) begin
            errors++;
            $display("FAIL midreset_status: busy=%b pkt_seq=%h underrun=%b payload=%0d, required 0/0000/0/150",
                     busy, pkt_seq, underrun, pay_acc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.tx_eof_n !== 1'b1) eof_low++;
        end
        checks++;
        if (eof_low != 0) begin
            errors++;
            $display("FAIL midreset_eof: eof_n low %0d cycles, required 0", eof_low);
        end
    endtask

    initial begin
        test_reset();
        test_full_speed();
        test_random_dst();
        test_gap();
`ifdef PKT_TX_UNDERRUN_PAD_EN
        test_underrun_pad();
`endif
        test_seq_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
